// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
// Holds the FSM state encoding and the nibble counter width function.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_width(input int nib);
        return (nib <= 2) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice.
// Latency: zero cycles, purely combinational.
// Backpressure: none, it has no handshake.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is flattened to a two-level form rather than rippled.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_seq_adder.sv
// W-bit add/subtract that runs one 4-bit lookahead slice over NIB cycles.
// Latency: accept in cycle 0, result valid from cycle NIB+1.
// Backpressure: result is held in DONE until res_ready; start_ready only in IDLE.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NIB = W / 4;
    localparam int CW  = nib_width(NIB);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [CW-1:0] cnt;
    logic          last;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    slice_s;
    logic          slice_c3;
    logic          slice_c4;

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign last        = (cnt == CW'(NIB - 1));

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt == CW'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
    end

    cla_slice4 u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (slice_s),
        .c3 (slice_c3),
        .c4 (slice_c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = RUN;
            RUN:     if (last)        state_nxt = DONE;
            DONE:    if (res_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction is a + ~b + 1, so invert once at capture.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (cnt == CW'(k)) sum[4*k +: 4] <= slice_s;
                    end
                    carry_q <= slice_c4;
                    if (last) begin
                        cout <= slice_c4;
                        ovf  <= slice_c3 ^ slice_c4;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at W=16.
// Expected results are queued at acceptance and popped when res_valid rises.
module tb_cla_seq_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] yy;
        logic         ci;
        logic [W:0]   full;
        logic [W-1:0] low;
        res_t         r;
        yy    = s ? ~y : y;
        ci    = s ? 1'b1 : c;
        full  = {1'b0, x} + {1'b0, yy} + (W+1)'(ci);
        low   = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(ci);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, queue the expected result.
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, input logic s, input res_t exp);
        int n;
        n           = 0;
        a           = aa;
        b           = bb;
        cin         = ci;
        sub         = s;
        start_valid = 1'b1;
        while (!start_ready && n < 50) begin
            step();
            n++;
        end
        if (!start_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_accept: start_ready=%b required 1 within 50 cycles", start_ready);
        end else begin
            step();
            exp_q.push_back(exp);
        end
        start_valid = 1'b0;
        a           = $urandom;
        b           = $urandom;
    endtask

    // Wait for the result, check latency and value, then pop it.
    task automatic receive(input string name, input int exp_lat);
        int   n;
        res_t e;
        n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (!res_valid || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: res_valid=%b queued=%0d required result", name,
                     res_valid, exp_q.size());
        end else begin
            if (exp_lat >= 0) begin
                n_checks++;
                if (n !== exp_lat) begin
                    n_fail++;
                    $display("FAIL %s_latency: got %0d cycles required %0d", name, n, exp_lat);
                end
            end
            e = exp_q.pop_front();
            if ({sum, cout, ovf} !== e) begin
                n_fail++;
                $display("FAIL %s_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                         name, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            n_checks++;
            if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_pop: res_valid=%b start_ready=%b required 0/1", name,
                         res_valid, start_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({start_ready, res_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: start_ready=%b res_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
                     start_ready, res_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_basic();
        send(16'h1234, 16'h0FCD, 1'b0, 1'b0, '{sum: 16'h2201, cout: 1'b0, ovf: 1'b0});
        receive("add_basic", NIB);
    endtask

    task automatic test_carry_chain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        receive("carry_chain", NIB);
    endtask

    task automatic test_overflow();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
        receive("ovf_pos", NIB);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b1});
        receive("ovf_neg", NIB);
    endtask

    task automatic test_sub();
        send(16'h0005, 16'h0007, 1'b1, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
        receive("sub_borrow", NIB);
    endtask

    task automatic test_backpressure();
        res_t e;
        int   n;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, '{sum: 16'h3333, cout: 1'b0, ovf: 1'b0});
        n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        e           = exp_q.pop_front();
        a           = 16'h00FF;
        b           = 16'h0F01;
        cin         = 1'b0;
        sub         = 1'b0;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({res_valid, start_ready, sum, cout, ovf} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: res_valid=%b start_ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                         i, res_valid, start_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_early_accept: start_ready=%b res_valid=%b required 1 0",
                     start_ready, res_valid);
        end
        step();
        start_valid = 1'b0;
        exp_q.push_back('{sum: 16'h1000, cout: 1'b0, ovf: 1'b0});
        receive("bp_next", NIB);
    endtask

    task automatic test_reset_midrun();
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, model(16'hABCD, 16'h1111, 1'b0, 1'b0));
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res_valid, start_ready, sum} !== {1'b0, 1'b1, 16'h0}) begin
            n_fail++;
            $display("FAIL midrun_reset: res_valid=%b start_ready=%b sum=%h required 0 1 0000",
                     res_valid, start_ready, sum);
        end
        exp_q.delete();
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            step();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_no_emit%0d: res_valid=%b required 0", i, res_valid);
            end
        end
        send(16'h0001, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0002, cout: 1'b0, ovf: 1'b0});
        receive("after_reset", NIB);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic         s;
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            c = 1'($urandom);
            s = 1'($urandom);
            send(x, y, c, s, model(x, y, c, s));
            receive("b2b", NIB);
        end
    endtask

    initial begin
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        test_reset();
        test_add_basic();
        test_carry_chain();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
